vx_fpu_tag_tracker: RTL and testbench

Tracks in-flight FPU requests for one FPU block. Each issued request gets a tag, and its writeback metadata is stored against that tag. When the FPU returns the tag, the metadata is restored and the response is released downstream. It also accumulates floating-point exception flags per warp across multi-packet (sop/eop) instructions, so interleaved warps never corrupt each other's flags. Configurable depth, metadata width, warp count, and in-order or out-of-order release.

---
 rtl/vx_fpu_tag_tracker.sv | 182 ++++++++++++++++++
 tb/tb_vx_fpu_tag_tracker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fpu_tag_tracker.sv
// vx_fpu_tag_tracker
//   Tag allocator and writeback-metadata store for one FPU block. Each issued
//   request gets a tag. The request's {wid, sop, eop, meta} is kept against
//   that tag. The FPU response for the tag restores it combinationally on
//   out_*. Exception flags are accumulated per warp across sop..eop packets.
//   The accumulated flags are emitted on the csr_write_* strobe when eop
//   releases.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   req_*              request side: valid/ready handshake, wid/sop/eop/meta
//                      to store, req_tag = tag granted this cycle
//   rsp_*              FPU result side: returned tag plus optional fflags
//   out_*              restored metadata toward commit, out_ready backpressure
//   csr_write_*        per-warp fflags write on the last packet of an instr
//   count, empty       occupancy

// Per-warp flag accumulator: one instance per warp.
module vx_fpu_tag_tracker_wacc (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd,        // release of a packet belonging to this warp
  input  logic       eop,
  input  logic       has_fflags,
  input  logic [4:0] fflags,     // already masked by has_fflags
  output logic [4:0] acc,
  output logic       seen
);
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      seen <= 1'b0;
    end else if (upd) begin
      if (eop) begin
        acc  <= '0;
        seen <= 1'b0;
      end else begin
        acc  <= acc | fflags;
        seen <= seen | has_fflags;
      end
    end
  end
endmodule

module vx_fpu_tag_tracker #(
  parameter  int SIZE       = 8,
  parameter  int META_WIDTH = 64,
  parameter  int NUM_WARPS  = 4,
  parameter  int IN_ORDER   = 0,
  localparam int TAG_WIDTH  = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int NW_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CNT_W      = $clog2(SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NW_W-1:0]       req_wid,
  input  logic                  req_sop,
  input  logic                  req_eop,
  input  logic [META_WIDTH-1:0] req_meta,
  output logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_has_fflags,
  input  logic [4:0]            rsp_fflags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NW_W-1:0]       out_wid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [META_WIDTH-1:0] out_meta,
  output logic                  csr_write_enable,
  output logic [NW_W-1:0]       csr_write_wid,
  output logic [4:0]            csr_write_fflags,
  output logic [CNT_W-1:0]      count,
  output logic                  empty
);

  typedef struct packed {
    logic [NW_W-1:0]       wid;
    logic                  sop;
    logic                  eop;
    logic [META_WIDTH-1:0] meta;
  } ent_t;

  ent_t                 ent_mem [SIZE];
  logic [SIZE-1:0]      vld_r;
  logic [TAG_WIDTH-1:0] wr_ptr, rd_ptr, free_tag;
  logic [CNT_W-1:0]     count_r, count_next;
  logic                 full_r;
  logic                 acq_fire, rel_fire, ok;
  ent_t                 rsp_ent;

  function automatic logic [TAG_WIDTH-1:0] ptr_inc(input logic [TAG_WIDTH-1:0] p);
    return (p == TAG_WIDTH'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest-index free entry; scanning downward lets the lowest index win.
  always_comb begin
    free_tag = '0;
    for (int i = SIZE - 1; i >= 0; i--)
      if (!vld_r[i]) free_tag = TAG_WIDTH'(i);
  end

  // Full is registered, so a release in a full cycle cannot feed an acquire.
  assign req_ready = ~full_r;
  assign acq_fire  = req_valid & req_ready;
  assign req_tag   = (IN_ORDER != 0) ? wr_ptr : free_tag;

  // In-order mode only releases the oldest tag; others wait upstream.
  assign ok        = (IN_ORDER == 0) || (rsp_tag == rd_ptr);
  assign out_valid = rsp_valid & ok;
  assign rsp_ready = out_ready & ok;
  assign rel_fire  = rsp_valid & rsp_ready;

  assign rsp_ent   = ent_mem[rsp_tag];
  assign out_wid   = rsp_ent.wid;
  assign out_sop   = rsp_ent.sop;
  assign out_eop   = rsp_ent.eop;
  assign out_meta  = rsp_ent.meta;

  assign count_next = count_r + CNT_W'(acq_fire) - CNT_W'(rel_fire);
  assign count      = count_r;
  assign empty      = (count_r == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r   <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      // Acquire and release never hit the same index: a released entry is valid.
      if (acq_fire) vld_r[req_tag] <= 1'b1;
      if (rel_fire) vld_r[rsp_tag] <= 1'b0;
      count_r <= count_next;
      full_r  <= (count_next == CNT_W'(SIZE));
      if (acq_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (rel_fire) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Payload store needs no reset; validity lives in vld_r.
  always_ff @(posedge clk) begin
    if (acq_fire) ent_mem[req_tag] <= '{req_wid, req_sop, req_eop, req_meta};
  end

  // Per-warp fflags accumulation
  logic [NUM_WARPS-1:0][4:0] acc;
  logic [NUM_WARPS-1:0]      seen;
  logic [NW_W-1:0]           w;
  logic [4:0]                f;

  assign w = rsp_ent.wid;
  assign f = rsp_has_fflags ? rsp_fflags : 5'b0;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_wacc
    vx_fpu_tag_tracker_wacc u_wacc (
      .clk        (clk),
      .reset      (reset),
      .upd        (rel_fire & (w == NW_W'(g))),
      .eop        (rsp_ent.eop),
      .has_fflags (rsp_has_fflags),
      .fflags     (f),
      .acc        (acc[g]),
      .seen       (seen[g])
    );
  end

  // Skip the CSR write when no packet of the instruction reported flags.
  assign csr_write_enable = rel_fire & rsp_ent.eop & (seen[w] | rsp_has_fflags);
  assign csr_write_wid    = w;
  assign csr_write_fflags = acc[w] | f;

  // A response for a tag that was never issued is an upstream bug.
  a_rsp_tag_valid : assert property (@(posedge clk) disable iff (reset)
    rsp_valid |-> vld_r[rsp_tag]);

endmodule

// File: tb/tb_vx_fpu_tag_tracker.sv
module tb_vx_fpu_tag_tracker;
  localparam int SIZE = 4, MW = 16, NWARP = 4;

  typedef struct packed {
    logic [1:0]    wid;
    logic          sop;
    logic          eop;
    logic [MW-1:0] meta;
  } exp_t;

  logic clk = 1'b0, reset;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DUT A: out-of-order release
  logic          a_req_valid, a_req_ready, a_req_sop, a_req_eop;
  logic [1:0]    a_req_wid, a_req_tag, a_rsp_tag, a_out_wid, a_csr_wid;
  logic [MW-1:0] a_req_meta, a_out_meta;
  logic          a_rsp_valid, a_rsp_ready, a_rsp_has;
  logic [4:0]    a_rsp_ff, a_csr_ff;
  logic          a_out_valid, a_out_ready, a_out_sop, a_out_eop, a_csr_we, a_empty;
  logic [2:0]    a_count;

  vx_fpu_tag_tracker #(.SIZE(SIZE), .META_WIDTH(MW), .NUM_WARPS(NWARP), .IN_ORDER(0)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wid(a_req_wid),
    .req_sop(a_req_sop), .req_eop(a_req_eop), .req_meta(a_req_meta), .req_tag(a_req_tag),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_tag(a_rsp_tag),
    .rsp_has_fflags(a_rsp_has), .rsp_fflags(a_rsp_ff),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_wid(a_out_wid),
    .out_sop(a_out_sop), .out_eop(a_out_eop), .out_meta(a_out_meta),
    .csr_write_enable(a_csr_we), .csr_write_wid(a_csr_wid), .csr_write_fflags(a_csr_ff),
    .count(a_count), .empty(a_empty)
  );

  // DUT B: in-order release
  logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_out_valid;
  logic          b_out_sop, b_out_eop, b_csr_we, b_empty;
  logic [1:0]    b_req_tag, b_rsp_tag, b_out_wid, b_csr_wid;
  logic [MW-1:0] b_req_meta, b_out_meta;
  logic [4:0]    b_csr_ff;
  logic [2:0]    b_count;

  vx_fpu_tag_tracker #(.SIZE(SIZE), .META_WIDTH(MW), .NUM_WARPS(NWARP), .IN_ORDER(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wid(2'd0),
    .req_sop(1'b1), .req_eop(1'b1), .req_meta(b_req_meta), .req_tag(b_req_tag),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_tag(b_rsp_tag),
    .rsp_has_fflags(1'b0), .rsp_fflags(5'd0),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_wid(b_out_wid),
    .out_sop(b_out_sop), .out_eop(b_out_eop), .out_meta(b_out_meta),
    .csr_write_enable(b_csr_we), .csr_write_wid(b_csr_wid), .csr_write_fflags(b_csr_ff),
    .count(b_count), .empty(b_empty)
  );

  // Reference model + scoreboards
  bit         m_vld [SIZE];
  exp_t       m_ent [SIZE];
  logic [4:0] m_acc [NWARP];
  bit         m_seen[NWARP];
  exp_t       a_q[$];
  logic [6:0] c_q[$];
  logic [MW-1:0] b_q[$];
  logic [MW-1:0] b_meta [SIZE];
  int         b_wr, b_rd;

  function automatic int m_free();
    for (int i = 0; i < SIZE; i++) if (!m_vld[i]) return i;
    return -1;
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < SIZE; i++) n += int'(m_vld[i]);
    return n;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < SIZE; i++) m_vld[i] = 0;
    for (int i = 0; i < NWARP; i++) begin m_acc[i] = '0; m_seen[i] = 0; end
    b_wr = 0; b_rd = 0;
  endfunction

  // Models one release of tag; returns whether a CSR write is expected.
  function automatic bit m_rel(input int tag, input bit has, input logic [4:0] ff);
    exp_t       en = m_ent[tag];
    logic [1:0] w  = en.wid;
    logic [4:0] f  = has ? ff : 5'd0;
    bit         we = 0;
    a_q.push_back(en);
    if (en.eop) begin
      if (m_seen[w] || has) begin
        we = 1;
        c_q.push_back({w, m_acc[w] | f});
      end
      m_acc[w] = '0; m_seen[w] = 0;
    end else begin
      m_acc[w] |= f; m_seen[w] |= has;
    end
    m_vld[tag] = 0;
    return we;
  endfunction

  exp_t       a_pop;
  logic [6:0] c_pop;
  logic [MW-1:0] b_pop;

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      chk("a_sb_pending", a_q.size() > 0, 1);
      if (a_q.size() > 0) begin
        a_pop = a_q.pop_front();
        chk("a_out", {a_out_wid, a_out_sop, a_out_eop, a_out_meta}, a_pop);
      end
    end
    if (a_csr_we) begin
      chk("a_csr_pending", c_q.size() > 0, 1);
      if (c_q.size() > 0) begin
        c_pop = c_q.pop_front();
        chk("a_csr", {a_csr_wid, a_csr_ff}, c_pop);
      end
    end
    if (b_out_valid) begin
      chk("b_sb_pending", b_q.size() > 0, 1);
      if (b_q.size() > 0) begin
        b_pop = b_q.pop_front();
        chk("b_out_meta", b_out_meta, b_pop);
      end
    end
  end

  task automatic acq_a(input logic [1:0] wid, input bit sop, input bit eop,
                       input logic [MW-1:0] meta, output int tag);
    a_req_valid = 1; a_req_wid = wid; a_req_sop = sop; a_req_eop = eop; a_req_meta = meta;
    tag = m_free();
    @(negedge clk);
    chk("a_req_ready", a_req_ready, 1);
    chk("a_req_tag", a_req_tag, tag);
    m_vld[tag] = 1; m_ent[tag] = '{wid, sop, eop, meta};
    @(posedge clk); #1;
    a_req_valid = 0;
  endtask

  task automatic rel_a(input int tag, input bit has, input logic [4:0] ff);
    bit we;
    a_rsp_valid = 1; a_rsp_tag = 2'(tag); a_rsp_has = has; a_rsp_ff = ff;
    we = m_rel(tag, has, ff);
    @(negedge clk);
    chk("a_rsp_ready", a_rsp_ready, 1);
    chk("a_csr_we", a_csr_we, we);
    @(posedge clk); #1;
    a_rsp_valid = 0;
  endtask

  task automatic acq_b(input logic [MW-1:0] meta);
    b_req_valid = 1; b_req_meta = meta;
    @(negedge clk);
    chk("b_req_tag", b_req_tag, b_wr);
    b_meta[b_wr] = meta; b_wr = (b_wr + 1) % SIZE;
    @(posedge clk); #1;
    b_req_valid = 0;
  endtask

  task automatic rel_b(input int tag);
    bit go = (tag == b_rd);
    b_rsp_valid = 1; b_rsp_tag = 2'(tag);
    if (go) b_q.push_back(b_meta[tag]);
    @(negedge clk);
    chk("b_rsp_ready", b_rsp_ready, go);
    chk("b_out_valid", b_out_valid, go);
    if (go) b_rd = (b_rd + 1) % SIZE;
    @(posedge clk); #1;
    b_rsp_valid = 0;
  endtask

  int t[8];

  initial begin
    reset = 1;
    a_req_valid = 0; a_req_wid = 0; a_req_sop = 0; a_req_eop = 0; a_req_meta = 0;
    a_rsp_valid = 0; a_rsp_tag = 0; a_rsp_has = 0; a_rsp_ff = 0; a_out_ready = 1;
    b_req_valid = 0; b_req_meta = 0; b_rsp_valid = 0; b_rsp_tag = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    @(negedge clk);
    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_empty", a_empty, 1);
    chk("rst_count", a_count, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_csr_we", a_csr_we, 0);
    @(posedge clk); #1;

    // Fill / drain
    for (int i = 0; i < SIZE; i++) acq_a(2'd0, 1, 1, MW'(16'h10 + i), t[i]);
    @(negedge clk);
    chk("full_ready", a_req_ready, 0);
    chk("full_count", a_count, m_cnt());
    @(posedge clk); #1;
    rel_a(2, 0, 0);
    acq_a(2'd0, 1, 1, 16'h0022, t[0]);
    chk("reuse_tag2", t[0], 2);

    // Acquire + release in the same full cycle: acquire waits one cycle.
    a_req_valid = 1; a_req_wid = 0; a_req_sop = 1; a_req_eop = 1; a_req_meta = 16'h0055;
    a_rsp_valid = 1; a_rsp_tag = 0; a_rsp_has = 0; a_rsp_ff = 0;
    void'(m_rel(0, 0, 0));
    @(negedge clk);
    chk("full_stall_ready", a_req_ready, 0);
    @(posedge clk); #1;
    a_rsp_valid = 0;
    @(negedge clk);
    chk("after_stall_ready", a_req_ready, 1);
    chk("after_stall_tag", a_req_tag, m_free());
    m_vld[0] = 1; m_ent[0] = '{2'd0, 1'b1, 1'b1, 16'h0055};
    @(posedge clk); #1;
    a_req_valid = 0;
    @(negedge clk);
    chk("after_stall_count", a_count, m_cnt());
    @(posedge clk); #1;
    for (int i = 0; i < SIZE; i++) rel_a(i, 0, 0);
    @(negedge clk);
    chk("drain_empty", a_empty, 1);
    @(posedge clk); #1;

    // Out-of-order release
    for (int i = 0; i < 3; i++) acq_a(2'd0, 1, 1, MW'(16'hA0 + i), t[i]);
    rel_a(t[2], 0, 0); rel_a(t[0], 0, 0); rel_a(t[1], 0, 0);
    @(negedge clk);
    chk("ooo_empty", a_empty, 1);
    @(posedge clk); #1;

    // Interleaved per-warp flags
    acq_a(2'd1, 1, 0, 16'h0100, t[0]);
    acq_a(2'd2, 1, 0, 16'h0200, t[1]);
    acq_a(2'd1, 0, 1, 16'h0101, t[2]);
    acq_a(2'd2, 0, 1, 16'h0201, t[3]);
    rel_a(t[0], 1, 5'h01);
    rel_a(t[1], 1, 5'h04);
    rel_a(t[2], 0, 5'h00);
    rel_a(t[3], 1, 5'h02);

    // eop with no flags anywhere: no CSR write
    acq_a(2'd3, 1, 1, 16'h0300, t[0]);
    rel_a(t[0], 0, 0);

    // Backpressure must not touch the accumulator
    acq_a(2'd3, 1, 0, 16'h0310, t[0]);
    acq_a(2'd3, 0, 1, 16'h0311, t[1]);
    a_out_ready = 0; a_rsp_valid = 1; a_rsp_tag = 2'(t[0]); a_rsp_has = 1; a_rsp_ff = 5'h10;
    repeat (2) begin
      @(negedge clk);
      chk("bp_rsp_ready", a_rsp_ready, 0);
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_csr_we", a_csr_we, 0);
      @(posedge clk); #1;
    end
    a_rsp_valid = 0; a_out_ready = 1;
    rel_a(t[0], 0, 0);
    rel_a(t[1], 0, 0);

    // Reset with entries outstanding and a dirty warp-1 accumulator
    for (int i = 0; i < 3; i++) acq_a(2'd1, 1, 0, MW'(16'h0400 + i), t[i]);
    rel_a(t[0], 1, 5'h08);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    m_reset();
    @(negedge clk);
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_empty", a_empty, 1);
    chk("mid_rst_ready", a_req_ready, 1);
    @(posedge clk); #1;
    acq_a(2'd1, 1, 1, 16'h0500, t[0]);
    chk("mid_rst_tag0", t[0], 0);
    rel_a(t[0], 0, 0);

    // In-order instance
    acq_b(16'hB000); acq_b(16'hB001);
    rel_b(1);
    rel_b(0);
    rel_b(1);
    for (int i = 0; i < 3; i++) acq_b(MW'(16'hB100 + i));
    for (int i = 0; i < 3; i++) rel_b((2 + i) % SIZE);
    @(negedge clk);
    chk("b_empty", b_empty, 1);

    chk("a_q_drained", a_q.size(), 0);
    chk("c_q_drained", c_q.size(), 0);
    chk("b_q_drained", b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
